// File: rtl/comparador_pkg.sv
// Shared definitions for the bit-serial magnitude comparator: state encoding
// and the bit-index width helper.
package comparador_pkg;

    localparam logic [1:0] IDLE_ENC = 2'd0;
    localparam logic [1:0] RUN_ENC  = 2'd1;
    localparam logic [1:0] DONE_ENC = 2'd2;

    typedef enum logic [1:0] {
        IDLE = IDLE_ENC,
        RUN  = RUN_ENC,
        DONE = DONE_ENC
    } state_t;

    // A one-bit operand still needs a one-bit index register.
    function automatic int idx_width(input int k);
        return (k <= 1) ? 1 : $clog2(k);
    endfunction

endpackage

// File: rtl/celda_serial_di.sv
// One-bit comparison cell, evaluated right to left: n_out = (A[i:0] > B[i:0])
// given n_in = (A[i-1:0] > B[i-1:0]). primera selects the LSB form.
module celda_serial_di (
    input  logic a,
    input  logic b,
    input  logic n_in,
    input  logic primera,
    output logic n_out
);

    logic gana;
    logic iguales;

    assign gana    = a & ~b;
    assign iguales = ~(a ^ b);
    assign n_out   = primera ? gana : (gana | (iguales & n_in));

endmodule

// File: rtl/comparador_serial.sv
// Bit-serial A > B comparator: one shared cell stepped LSB to MSB, one bit per
// clock, with a start/busy/done handshake and a per-bit partial-result trace N.
module comparador_serial
    import comparador_pkg::*;
#(
    parameter int K = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    input  logic [K-1:0] A,
    input  logic [K-1:0] B,
    output logic         busy,
    output logic         done,
    output logic [K-1:0] N,
    output logic         Z
);

    localparam int            IW       = idx_width(K);
    localparam logic [IW-1:0] IDX_LAST = IW'(K - 1);

    state_t        state_reg;
    state_t        state_next;
    logic [IW-1:0] idx_reg;
    logic [K-1:0]  a_reg;
    logic [K-1:0]  b_reg;
    logic [K-1:0]  n_reg;
    logic          carry_reg;
    logic          z_reg;
    logic          accept;
    logic          primera;
    logic          n_out;

    // start only counts when no run is in flight
    assign accept  = start && (state_reg == IDLE || state_reg == DONE);
    assign primera = (idx_reg == '0);

    celda_serial_di u_celda (
        .a      (a_reg[idx_reg]),
        .b      (b_reg[idx_reg]),
        .n_in   (carry_reg),
        .primera(primera),
        .n_out  (n_out)
    );

    always_comb begin
        state_next = state_reg;
        busy       = 1'b0;
        done       = 1'b0;
        case (state_reg)
            IDLE: begin
                if (start) state_next = RUN;
            end
            RUN: begin
                busy = 1'b1;
                if (idx_reg == IDX_LAST) state_next = DONE;
            end
            DONE: begin
                done       = 1'b1;
                state_next = start ? RUN : IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg <= IDLE;
            idx_reg   <= '0;
            a_reg     <= '0;
            b_reg     <= '0;
            n_reg     <= '0;
            carry_reg <= 1'b0;
            z_reg     <= 1'b0;
        end else begin
            state_reg <= state_next;
            if (accept) begin
                a_reg     <= A;
                b_reg     <= B;
                n_reg     <= '0;
                idx_reg   <= '0;
                carry_reg <= 1'b0;
                z_reg     <= 1'b0;
            end else if (state_reg == RUN) begin
                n_reg[idx_reg] <= n_out;
                carry_reg      <= n_out;
                // The index parks on the MSB rather than wrapping; start reloads it.
                if (idx_reg == IDX_LAST) begin
                    z_reg <= n_out;
                end else begin
                    idx_reg <= idx_reg + IW'(1);
                end
            end
        end
    end

    assign N = n_reg;
    assign Z = z_reg;

endmodule
